// File: rtl/marker_nop_injector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : marker_nop_injector_pkg
// Description : Shared opcodes, FSM/marker-kind enums and the marker builder
//               for the marker NOP injector.
// Revision    : 1.0 - initial release
// ============================================================================
package marker_nop_injector_pkg;

   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;

   typedef enum logic {
      PASS   = 1'b0,
      INJECT = 1'b1
   } state_t;

   typedef enum logic {
      MK_RET  = 1'b0,
      MK_CALL = 1'b1
   } mkind_t;

   // ADDI x0,x0,imm : architecturally a NOP, the immediate tags the marker kind
   function automatic logic [31:0] build_marker(input logic [4:0] imm);
      return {7'b0, imm, 5'b0, 3'b000, 5'b0, OPC_OP_IMM};
   endfunction

endpackage
`default_nettype wire

// File: rtl/marker_nop_injector_cf_classify.sv
`default_nettype none
// ============================================================================
// Module      : cf_classify
// Description : Combinational call/return classifier for a raw 32-bit
//               instruction. Return wins over call when both match.
// Revision    : 1.0 - initial release
// ============================================================================
module cf_classify
   import marker_nop_injector_pkg::*;
(
   input  logic [31:0] instr,
   output logic        is_call,
   output logic        is_ret
);

   logic       w_full;
   logic [6:0] w_opc;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   logic       w_ret_raw;
   logic       w_call_raw;
   logic       w_unused;

   assign w_full = (instr[1:0] == 2'b11);
   assign w_opc  = instr[6:0];
   assign w_rd   = instr[11:7];
   assign w_rs1  = instr[19:15];

   // Immediate and funct3 fields play no part in the classification
   assign w_unused = ^{instr[31:20], instr[14:12]};

   assign w_ret_raw  = w_full && (w_opc == OPC_JALR) && (w_rd == 5'd0) && (w_rs1 == 5'd1);
   assign w_call_raw = w_full && ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) && (w_rd != 5'd0);

   assign is_ret  = w_ret_raw;
   assign is_call = w_call_raw && !w_ret_raw;

endmodule
`default_nettype wire

// File: rtl/marker_nop_injector.sv
`default_nettype none
// ============================================================================
// Module      : marker_nop_injector
// Description : Zero-latency instruction pass-through that injects one
//               ADDI x0,x0,imm marker after every accepted call or return.
//               Optional macro MARKER_NOP_CNT_EN adds a saturating count of
//               emitted markers; otherwise marker_cnt_o is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module marker_nop_injector
   import marker_nop_injector_pkg::*;
#(
   parameter logic [4:0] NOP_IMM_RET  = 5'h1,
   parameter logic [4:0] NOP_IMM_CALL = 5'h2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        en_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [63:0] pc_i,
   input  logic        ex_valid_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instr_o,
   output logic [63:0] pc_o,
   output logic        ex_valid_o,
   output logic        marker_o,
   output logic [31:0] marker_cnt_o
);

   state_t      r_state;
   mkind_t      r_kind;
   logic [63:0] r_pc;

   logic        w_is_call;
   logic        w_is_ret;
   logic        w_trigger;
   logic        w_inject;
   logic [4:0]  w_imm;

   cf_classify u_cf_classify (
      .instr   (instr_i),
      .is_call (w_is_call),
      .is_ret  (w_is_ret)
   );

   // In PASS ready_o mirrors ready_i, so the input handshake is valid_i && ready_i
   assign w_trigger = (r_state == PASS) && valid_i && ready_i && en_i
                      && !ex_valid_i && !flush_i && (w_is_call || w_is_ret);

   // Reset overrides a pending marker on the outputs as well as the state
   assign w_inject = (r_state == INJECT) && !rst_i;
   assign w_imm    = (r_kind == MK_RET) ? NOP_IMM_RET : NOP_IMM_CALL;

   // FSM: latch marker kind and trigger PC on a qualifying handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= PASS;
         r_kind  <= MK_RET;
         r_pc    <= 64'd0;
      end else if (flush_i) begin
         r_state <= PASS;
      end else begin
         case (r_state)
            PASS: begin
               if (w_trigger) begin
                  r_state <= INJECT;
                  r_kind  <= w_is_ret ? MK_RET : MK_CALL;
                  r_pc    <= pc_i;
               end
            end
            INJECT: begin
               if (ready_i) begin
                  r_state <= PASS;
               end
            end
            default: r_state <= PASS;
         endcase
      end
   end

   // Output mux: zero-latency pass-through, or the latched marker
   always_comb begin
      valid_o    = valid_i;
      ready_o    = ready_i;
      instr_o    = instr_i;
      pc_o       = pc_i;
      ex_valid_o = ex_valid_i;
      marker_o   = 1'b0;
      if (w_inject) begin
         valid_o    = 1'b1;
         ready_o    = 1'b0;
         instr_o    = build_marker(w_imm);
         pc_o       = r_pc + 64'd4;
         ex_valid_o = 1'b0;
         marker_o   = 1'b1;
      end
   end

`ifdef MARKER_NOP_CNT_EN
   logic [31:0] r_cnt;

   // Saturating count of marker output handshakes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= 32'd0;
      end else if (w_inject && ready_i && (r_cnt != 32'hFFFF_FFFF)) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign marker_cnt_o = r_cnt;
`else
   assign marker_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_marker_nop_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_marker_nop_injector
// Description : Self-checking bench: directed literal checks plus randomized
//               traffic compared every cycle against a pending-marker model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_marker_nop_injector;

   logic        clk_i      = 1'b0;
   logic        rst_i      = 1'b1;
   logic        flush_i    = 1'b0;
   logic        en_i       = 1'b0;
   logic        valid_i    = 1'b0;
   logic        ready_i    = 1'b0;
   logic [31:0] instr_i    = 32'd0;
   logic [63:0] pc_i       = 64'd0;
   logic        ex_valid_i = 1'b0;

   logic        ready_o;
   logic        valid_o;
   logic [31:0] instr_o;
   logic [63:0] pc_o;
   logic        ex_valid_o;
   logic        marker_o;
   logic [31:0] marker_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MARKER_NOP_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   marker_nop_injector #(
      .NOP_IMM_RET  (5'h1),
      .NOP_IMM_CALL (5'h2)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .en_i         (en_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .instr_i      (instr_i),
      .pc_i         (pc_i),
      .ex_valid_i   (ex_valid_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .instr_o      (instr_o),
      .pc_o         (pc_o),
      .ex_valid_o   (ex_valid_o),
      .marker_o     (marker_o),
      .marker_cnt_o (marker_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- behavioural model ----------------
   // 0 = not a control-flow trigger, 1 = return, 2 = call
   function automatic int cf_kind(input logic [31:0] w);
      int opc, rd, rs1;
      opc = int'(w[6:0]);
      rd  = int'(w[11:7]);
      rs1 = int'(w[19:15]);
      if (w[1:0] != 2'b11) return 0;
      if (opc == 'h67 && rd == 0 && rs1 == 1) return 1;
      if ((opc == 'h6F || opc == 'h67) && rd != 0) return 2;
      return 0;
   endfunction

   // Queue holding at most one marker {word, pc} owed to the downstream side
   logic [95:0] pending_q[$];
   longint unsigned m_cnt = 0;
   bit model_on = 1'b0;

   // Per-cycle comparison of every output against the model, then model update
   always @(negedge clk_i) begin
      if (model_on) begin
         bit          inj;
         logic [31:0] e_instr;
         logic [63:0] e_pc;
         logic        e_valid, e_ready, e_ex, e_mk;
         logic [31:0] e_cnt;
         inj     = (pending_q.size() != 0) && !rst_i;
         e_valid = inj ? 1'b1 : valid_i;
         e_ready = inj ? 1'b0 : ready_i;
         e_instr = inj ? pending_q[0][95:64] : instr_i;
         e_pc    = inj ? pending_q[0][63:0]  : pc_i;
         e_ex    = inj ? 1'b0 : ex_valid_i;
         e_mk    = inj;
         e_cnt   = CNT_ON ? 32'(m_cnt) : 32'd0;
         n_tests++;
         if (valid_o !== e_valid || ready_o !== e_ready || instr_o !== e_instr ||
             pc_o !== e_pc || ex_valid_o !== e_ex || marker_o !== e_mk ||
             marker_cnt_o !== e_cnt) begin
            n_fail++;
            $display("FAIL model t=%0t got v=%b r=%b i=%h pc=%h ex=%b mk=%b cnt=%0d required v=%b r=%b i=%h pc=%h ex=%b mk=%b cnt=%0d",
                     $time, valid_o, ready_o, instr_o, pc_o, ex_valid_o, marker_o, marker_cnt_o,
                     e_valid, e_ready, e_instr, e_pc, e_ex, e_mk, e_cnt);
         end
         // next-state of the model
         if (rst_i) begin
            pending_q.delete();
            m_cnt = 0;
         end else begin
            if (inj && ready_i && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (flush_i) begin
               pending_q.delete();
            end else if (inj) begin
               if (ready_i) void'(pending_q.pop_front());
            end else if (valid_i && ready_i && en_i && !ex_valid_i && cf_kind(instr_i) != 0) begin
               logic [31:0] mw;
               mw = (32'((cf_kind(instr_i) == 1) ? 1 : 2) << 20) | 32'h13;
               pending_q.push_back({mw, pc_i + 64'd4});
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic drive(input logic r, input logic f, input logic e, input logic v,
                        input logic [31:0] ins, input logic [63:0] pc,
                        input logic ex, input logic rdy);
      @(posedge clk_i);
      #1;
      rst_i = r; flush_i = f; en_i = e; valid_i = v;
      instr_i = ins; pc_i = pc; ex_valid_i = ex; ready_i = rdy;
      @(negedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   localparam logic [31:0] RET   = 32'h0000_8067;
   localparam logic [31:0] CALL  = 32'h0000_00EF;
   localparam logic [31:0] JX5   = 32'h0002_8067;
   localparam logic [31:0] NOP_R = 32'h0010_0013;
   localparam logic [31:0] NOP_C = 32'h0020_0013;
   localparam logic [31:0] OTHER = 32'h0051_0093;

   initial begin
      model_on = 1'b1;
      // reset state
      drive(1, 0, 1, 1, RET, 64'h40, 0, 1);
      drive(1, 0, 1, 1, RET, 64'h40, 0, 1);
      chk("rst_marker", 64'(marker_o), 64'd0);
      chk("rst_valid",  64'(valid_o), 64'd1);
      chk("rst_cnt",    64'(marker_cnt_o), 64'd0);

      // return: pass-through then marker
      drive(0, 0, 1, 1, RET, 64'h8000_0000, 0, 1);
      chk("ret_pass_instr", 64'(instr_o), 64'(RET));
      chk("ret_pass_mk",    64'(marker_o), 64'd0);
      drive(0, 0, 1, 1, OTHER, 64'h8000_0004, 0, 1);
      chk("ret_mk_instr", 64'(instr_o), 64'(NOP_R));
      chk("ret_mk_pc",    pc_o, 64'h8000_0004);
      chk("ret_mk_flag",  64'(marker_o), 64'd1);
      chk("ret_mk_ready", 64'(ready_o), 64'd0);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("ret_done", 64'(marker_o), 64'd0);

      // call
      drive(0, 0, 1, 1, CALL, 64'h1000, 0, 1);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("call_mk_instr", 64'(instr_o), 64'(NOP_C));
      chk("call_mk_pc",    pc_o, 64'h1004);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("call_cnt", 64'(marker_cnt_o), CNT_ON ? 64'd2 : 64'd0);

      // backpressure: held three cycles, emitted on the fourth
      drive(0, 0, 1, 1, RET, 64'h2000, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, CALL, 64'h0, 0, 0);
         chk("bp_hold_mk",    64'(marker_o), 64'd1);
         chk("bp_hold_valid", 64'(valid_o), 64'd1);
         chk("bp_hold_instr", 64'(instr_o), 64'(NOP_R));
      end
      drive(0, 0, 0, 1, CALL, 64'h0, 0, 1);
      chk("bp_emit", 64'(marker_o), 64'd1);
      drive(0, 0, 0, 0, OTHER, 64'h0, 0, 1);
      chk("bp_single", 64'(marker_o), 64'd0);
      chk("bp_cnt", 64'(marker_cnt_o), CNT_ON ? 64'd3 : 64'd0);

      // flush while a marker is pending
      drive(0, 0, 1, 1, CALL, 64'h3000, 0, 1);
      drive(0, 1, 1, 0, OTHER, 64'h0, 0, 0);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("flush_mk",    64'(marker_o), 64'd0);
      chk("flush_valid", 64'(valid_o), 64'd0);
      chk("flush_cnt",   64'(marker_cnt_o), CNT_ON ? 64'd3 : 64'd0);

      // disabled, exception, jalr x0 via x5, compressed: no marker
      drive(0, 0, 0, 1, RET, 64'h10, 0, 1);
      drive(0, 0, 0, 0, OTHER, 64'h0, 0, 1);
      chk("dis_mk", 64'(marker_o), 64'd0);
      drive(0, 0, 1, 1, RET, 64'h10, 1, 1);
      chk("ex_pass", 64'(ex_valid_o), 64'd1);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("ex_mk", 64'(marker_o), 64'd0);
      drive(0, 0, 1, 1, JX5, 64'h10, 0, 1);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("jx5_mk", 64'(marker_o), 64'd0);
      drive(0, 0, 1, 1, 32'h0000_8082, 64'h10, 0, 1);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("rvc_mk", 64'(marker_o), 64'd0);

      // reset in the middle of a pending marker
      drive(0, 0, 1, 1, RET, 64'h5000, 0, 1);
      drive(1, 0, 1, 0, OTHER, 64'h0, 0, 0);
      chk("rstmid_mk",    64'(marker_o), 64'd0);
      chk("rstmid_valid", 64'(valid_o), 64'd0);
      drive(0, 0, 1, 0, OTHER, 64'h0, 0, 1);
      chk("rstmid_after", 64'(marker_o), 64'd0);
      chk("rstmid_cnt",   64'(marker_cnt_o), 64'd0);

      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 4000; c++) begin
         logic [31:0] ins;
         case ($urandom_range(0, 5))
            0: ins = RET;
            1: ins = CALL;
            2: ins = {$urandom_range(0, 4095) == 0 ? 12'h0 : 12'($urandom), 5'd1, 3'b000, 5'($urandom), 7'h67};
            3: ins = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h67};
            4: ins = {20'($urandom), 5'($urandom), 7'h6F};
            default: ins = $urandom;
         endcase
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               ins, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
               $urandom_range(0, 2) != 0);
      end

      @(posedge clk_i);
      #1;
      model_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/marker_nop_injector.md
MARKER_NOP_INJECTOR -- requirements
Module: marker_nop_injector

Interface
REQ-001 Parameters SHALL be: NOP_IMM_RET, default 5'h1, marker immediate after a return; NOP_IMM_CALL, default 5'h2, marker immediate after a call.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 flush_i  input  1  pipeline flush; discards any pending marker.
REQ-005 en_i  input  1  injection enable (CSR bit).
REQ-006 valid_i / ready_o  input / output  1 / 1  upstream handshake.
REQ-007 instr_i / pc_i  input  32 / 64  raw uncompressed instruction and its PC.
REQ-008 ex_valid_i  input  1  upstream exception attached to instr_i.
REQ-009 valid_o / ready_i  output / input  1 / 1  downstream handshake.
REQ-010 instr_o / pc_o / ex_valid_o  output  32 / 64 / 1  forwarded or injected instruction.
REQ-011 marker_o  output  1  high while the current output is an injected marker.
REQ-012 marker_cnt_o  output  32  injected-marker count (see Configuration).

Function
REQ-013 Return detection SHALL be: instr_i[1:0]==2'b11, opcode 7'h67, rd==0, rs1==1.
REQ-014 Call detection SHALL be: instr_i[1:0]==2'b11, opcode 7'h6F or 7'h67, rd!=0; return takes priority over call.
REQ-015 The marker SHALL be ADDI x0,x0,imm: {7'b0, imm[4:0], 5'b0, 3'b000, 5'b0, 7'h13}, imm = NOP_IMM_RET or NOP_IMM_CALL.
REQ-016 The FSM SHALL have states PASS and INJECT, with reset state PASS.
REQ-017 In PASS, outputs SHALL be combinational pass-through with zero latency: valid_o=valid_i, ready_o=ready_i, instr_o/pc_o/ex_valid_o from the inputs, and marker_o=0.
REQ-018 PASS->INJECT SHALL occur on an input handshake (valid_i && ready_o) of a detected call or return with en_i=1, ex_valid_i=0 and flush_i=0; the marker kind is latched at that edge.
REQ-019 In INJECT: ready_o=0, valid_o=1, instr_o=latched marker, pc_o=latched trigger PC + 4, ex_valid_o=0, marker_o=1.
REQ-020 INJECT->PASS SHALL occur on the cycle ready_i=1; back-to-back call/ret triggers each get their own marker, since no input is accepted while in INJECT.
REQ-021 flush_i=1 SHALL force PASS at the next edge from either state, with no marker emitted; flush_i has priority over the REQ-018 trigger.
REQ-022 en_i SHALL be sampled only at the trigger handshake; dropping en_i while in INJECT does not cancel the marker.
REQ-023 A trigger carrying ex_valid_i=1 or a compressed encoding SHALL pass through unmodified, with no injection.

Reset
REQ-024 While rst_i=1: state=PASS, latched marker and PC cleared, marker_cnt_o=0; valid_o follows valid_i (PASS), marker_o=0.
REQ-025 A reset asserted during INJECT SHALL abandon the pending marker, with no output of it after reset.

Configuration
REQ-026 Macro MARKER_NOP_CNT_EN defined: marker_cnt_o SHALL increment by 1 per marker output handshake (valid_o && ready_i && marker_o), saturating at 32'hFFFF_FFFF.
REQ-027 Macro MARKER_NOP_CNT_EN undefined: the counter SHALL be absent and marker_cnt_o SHALL be tied to 0.

Structure
REQ-028 The shared package SHALL hold: opcode constants (OPC_JAL 7'h6F, OPC_JALR 7'h67, OPC_OP_IMM 7'h13), the state enum {PASS, INJECT}, the marker kind enum {MK_RET, MK_CALL}, and the function building the marker word from an imm.
REQ-029 One sub-module, cf_classify, SHALL be purely combinational: instr_i -> {is_call, is_ret}; the FSM, latches and counter stay in the top.

Verification
REQ-030 ret: instr_i=32'h0000_8067, pc_i=0x8000_0000, en_i=1, ready_i=1 -> cycle 0 out 32'h0000_8067; cycle 1 out 32'h0010_0013, pc_o=0x8000_0004, marker_o=1, ready_o=0.
REQ-031 call: instr_i=32'h0000_00EF (jal ra) -> next output 32'h0020_0013; MARKER_NOP_CNT_EN defined -> marker_cnt_o=1 afterward.
REQ-032 backpressure: ret accepted, then ready_i=0 for 3 cycles -> valid_o=1 with marker held stable for 3 cycles, emitted on the 4th, one marker only.
REQ-033 flush: call accepted, flush_i=1 in the INJECT cycle with ready_i=0 -> no marker emitted, PASS next cycle, count unchanged.
REQ-034 disabled/exception: en_i=0 with ret, or en_i=1 with ret and ex_valid_i=1 -> no marker; jalr x0,0(x5)=32'h0002_8067 -> no marker.
REQ-035 reset mid-INJECT: rst_i=1 one cycle while a marker is pending -> marker_o=0, state PASS, marker_cnt_o=0.
